// File: rtl/gfx256_fragment.sv
// gfx256 fragment stage: flat or textured pixel color with color-key discard.
// Define GFX256_FRAG_LINE_CACHE_EN to add a one-line texture cache in front of the reader.
module gfx256_fragment #(
    parameter int point_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   texture_enable_i,
    input  logic                   colorkey_enable_i,
    input  logic [31:0]            colorkey_i,
    input  logic [1:0]             color_depth_i,
    input  logic [31:5]            tex0_base_i,
    input  logic [point_width-1:0] tex0_size_x_i,
    input  logic [point_width-1:0] tex0_size_y_i,
    input  logic [point_width-1:0] pixel_x_i,
    input  logic [point_width-1:0] pixel_y_i,
    input  logic [point_width-1:0] pixel_z_i,
    input  logic [point_width-1:0] u_i,
    input  logic [point_width-1:0] v_i,
    input  logic [7:0]             a_i,
    input  logic [31:0]            color_i,
    input  logic                   write_i,
    output logic                   ack_o,
    output logic [31:5]            texture_addr_o,
    output logic [31:0]            texture_sel_o,
    output logic                   texture_request_o,
    input  logic                   texture_ack_i,
    input  logic [255:0]           texture_data_i,
    input  logic                   wbm_busy_i,
    output logic [point_width-1:0] pixel_x_o,
    output logic [point_width-1:0] pixel_y_o,
    output logic [point_width-1:0] pixel_z_o,
    output logic [7:0]             pixel_alpha_o,
    output logic [31:0]            pixel_color_o,
    output logic                   write_o,
    input  logic                   ack_i
);

    typedef enum logic [2:0] {IDLE, ADDR1, ADDR2, FETCH, WRITE} state_t;

    localparam logic [point_width-1:0] PT_ONE = 1;

    state_t                 st_q, st_d;
    logic [point_width-1:0] u_q, v_q;
    logic [point_width-1:0] sx_eff, sy_eff, u_clamp, v_clamp;
    logic [31:0]            index_c, index_p1, offset_c;
    logic [31:5]            addr_c;
    logic [4:0]             lane_p2, src_lane;
    logic [255:0]           src_line;
    logic [31:0]            src_color;
    logic                   key_hit, pix_done, fetch_done, cache_hit;
    logic                   write_d, ack_d, req_d;

    function automatic logic [point_width-1:0] size_eff(input logic [point_width-1:0] size);
        return (size == '0) ? PT_ONE : size;
    endfunction

    function automatic logic [point_width-1:0] clamp_coord(input logic [point_width-1:0] c,
                                                           input logic [point_width-1:0] size);
        logic [point_width-1:0] lim;
        lim = size - PT_ONE;
        return (c > lim) ? lim : c;
    endfunction

    function automatic logic [31:0] depth_mask(input logic [1:0] depth);
        case (depth)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] extract_texel(input logic [255:0] line, input logic [4:0] lane,
                                                  input logic [1:0] depth);
        logic [255:0] sh;
        sh = line >> {lane, 3'b000};
        return sh[31:0] & depth_mask(depth);
    endfunction

    assign texture_sel_o = 32'hFFFF_FFFF;

    // ADDR1: clamp (u,v) into the texture and form the linear texel index
    assign sx_eff  = size_eff(tex0_size_x_i);
    assign sy_eff  = size_eff(tex0_size_y_i);
    assign u_clamp = clamp_coord(u_q, sx_eff);
    assign v_clamp = clamp_coord(v_q, sy_eff);
    assign index_c = 32'(v_clamp) * 32'(sx_eff) + 32'(u_clamp);

    // ADDR2: scale index to bytes, split into 32-byte line address and byte lane
    always_comb begin
        case (color_depth_i)
            2'b00:   offset_c = index_p1;
            2'b01:   offset_c = index_p1 << 1;
            default: offset_c = index_p1 << 2;
        endcase
    end
    assign addr_c     = tex0_base_i + offset_c[31:5];
    assign fetch_done = (st_q == FETCH) && texture_request_o && texture_ack_i;

`ifdef GFX256_FRAG_LINE_CACHE_EN
    logic         cache_vld, cfg_changed;
    logic [31:5]  cache_tag, base_seen;
    logic [1:0]   depth_seen;
    logic [255:0] cache_line;

    assign cfg_changed = (tex0_base_i != base_seen) || (color_depth_i != depth_seen);
    assign cache_hit   = cache_vld && !cfg_changed && (cache_tag == addr_c);
    assign src_line    = (st_q == FETCH) ? texture_data_i : cache_line;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cache_vld  <= 1'b0;
            base_seen  <= '0;
            depth_seen <= '0;
        end else begin
            base_seen  <= tex0_base_i;
            depth_seen <= color_depth_i;
            if (cfg_changed)     cache_vld <= 1'b0;
            else if (fetch_done) cache_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fetch_done) begin
            cache_tag  <= texture_addr_o;
            cache_line <= texture_data_i;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign src_line  = texture_data_i;
`endif

    // Final color: flat color in IDLE, texel on a cache hit or on fetch completion
    assign src_lane = (st_q == FETCH) ? lane_p2 : offset_c[4:0];
    always_comb begin
        src_color = color_i;
        if (st_q == ADDR2 || st_q == FETCH)
            src_color = extract_texel(src_line, src_lane, color_depth_i);
    end
    assign key_hit  = colorkey_enable_i &&
                      (((src_color ^ colorkey_i) & depth_mask(color_depth_i)) == 32'h0);
    assign pix_done = ((st_q == IDLE) && write_i && !texture_enable_i) ||
                      ((st_q == ADDR2) && cache_hit) || fetch_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) st_q <= IDLE;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (write_i) st_d = texture_enable_i ? ADDR1 : (key_hit ? IDLE : WRITE);
            ADDR1:   st_d = ADDR2;
            ADDR2:   st_d = cache_hit ? (key_hit ? IDLE : WRITE) : FETCH;
            FETCH:   if (fetch_done) st_d = key_hit ? IDLE : WRITE;
            WRITE:   if (ack_i) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        write_d = pix_done && !key_hit;
        ack_d   = (pix_done && key_hit) || ((st_q == WRITE) && ack_i);
        req_d   = 1'b0;
        if (st_q == ADDR2)
            req_d = !cache_hit && !wbm_busy_i;
        else if (st_q == FETCH)
            req_d = texture_request_o ? !texture_ack_i : !wbm_busy_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_o           <= 1'b0;
            ack_o             <= 1'b0;
            texture_request_o <= 1'b0;
        end else begin
            write_o           <= write_d;
            ack_o             <= ack_d;
            texture_request_o <= req_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pixel_x_o      <= '0;
            pixel_y_o      <= '0;
            pixel_z_o      <= '0;
            pixel_alpha_o  <= '0;
            pixel_color_o  <= '0;
            texture_addr_o <= '0;
        end else begin
            if (st_q == IDLE && write_i) begin
                pixel_x_o     <= pixel_x_i;
                pixel_y_o     <= pixel_y_i;
                pixel_z_o     <= pixel_z_i;
                pixel_alpha_o <= a_i;
            end
            if (st_q == ADDR2) texture_addr_o <= addr_c;
            if (write_d)       pixel_color_o  <= src_color;
        end
    end

    always_ff @(posedge clk_i) begin
        if (st_q == IDLE && write_i) begin
            u_q <= u_i;
            v_q <= v_i;
        end
        if (st_q == ADDR1) index_p1 <= index_c;
        if (st_q == ADDR2) lane_p2  <= offset_c[4:0];
    end

endmodule

// File: tb/tb_gfx256_fragment.sv
// Scoreboard bench for gfx256_fragment: stimulus pushes expected write/ack events, a monitor pops them.
module tb_gfx256_fragment;
    logic         clk = 1'b0;
    logic         rst_i;
    logic         texture_enable_i, colorkey_enable_i, write_i, ack_o, write_o;
    logic [31:0]  colorkey_i, color_i, texture_sel_o, pixel_color_o;
    logic [1:0]   color_depth_i;
    logic [26:0]  tex0_base_i, texture_addr_o;
    logic [15:0]  tex0_size_x_i, tex0_size_y_i, pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i;
    logic [15:0]  pixel_x_o, pixel_y_o, pixel_z_o;
    logic [7:0]   a_i, pixel_alpha_o;
    logic         texture_request_o, texture_ack_i, wbm_busy_i;
    logic [255:0] texture_data_i, ln;
    logic         ack_b, extra_ack;

    gfx256_fragment #(.point_width(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .texture_enable_i(texture_enable_i), .colorkey_enable_i(colorkey_enable_i),
        .colorkey_i(colorkey_i), .color_depth_i(color_depth_i), .tex0_base_i(tex0_base_i),
        .tex0_size_x_i(tex0_size_x_i), .tex0_size_y_i(tex0_size_y_i),
        .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
        .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i), .write_i(write_i),
        .ack_o(ack_o), .texture_addr_o(texture_addr_o), .texture_sel_o(texture_sel_o),
        .texture_request_o(texture_request_o), .texture_ack_i(texture_ack_i),
        .texture_data_i(texture_data_i), .wbm_busy_i(wbm_busy_i),
        .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
        .pixel_alpha_o(pixel_alpha_o), .pixel_color_o(pixel_color_o),
        .write_o(write_o), .ack_i(ack_b | extra_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          is_write;
        logic [31:0] color;
        int          at;
        logic [15:0] x;
        logic [7:0]  a;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input bit w, input logic [31:0] c, input int at,
                        input logic [15:0] x, input logic [7:0] a);
        exp_t e;
        e.is_write = w; e.color = c; e.at = at; e.x = x; e.a = a;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst_i && (write_o || ack_o)) begin
            if (exp_q.size() == 0) begin
                check32("unexpected_output", {30'b0, write_o, ack_o}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check32("out_write", {31'b0, write_o}, {31'b0, mon_e.is_write});
                check32("out_ack", {31'b0, ack_o}, {31'b0, !mon_e.is_write});
                check32("out_cycle", cyc, mon_e.at);
                if (mon_e.is_write) begin
                    check32("out_color", pixel_color_o, mon_e.color);
                    check32("out_x", {16'b0, pixel_x_o}, {16'b0, mon_e.x});
                    check32("out_alpha", {24'b0, pixel_alpha_o}, {24'b0, mon_e.a});
                end
            end
        end
    end

    // Blender model: acknowledges each write_o two cycles later
    initial begin
        ack_b = 1'b0;
        forever begin
            @(negedge clk);
            if (write_o && !rst_i) begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                ack_b = 1'b1;
                push(1'b0, 32'h0, cyc + 1, 16'h0, 8'h0);
                @(posedge clk); #1;
                ack_b = 1'b0;
            end
        end
    end

    task automatic start_pixel(input bit tex, input logic [15:0] x, input logic [15:0] u,
                               input logic [15:0] v, input logic [31:0] col, output int t0);
        @(posedge clk); #1;
        texture_enable_i = tex;
        pixel_x_i = x; pixel_y_i = x + 16'd1; pixel_z_i = x + 16'd2;
        u_i = u; v_i = v; color_i = col; a_i = x[7:0] ^ 8'h5A;
        write_i = 1'b1;
        t0 = cyc;
    endtask

    task automatic flat_pixel(input logic [15:0] x, input logic [31:0] col, input bit keyed);
        int t0;
        start_pixel(1'b0, x, 16'h0, 16'h0, col, t0);
        push(!keyed, col, t0 + 1, pixel_x_i, a_i);
        @(posedge clk); #1;
        write_i = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic tex_pixel(input logic [15:0] x, input logic [15:0] u, input logic [15:0] v,
                             input logic [26:0] exp_addr, input logic [255:0] line,
                             input logic [31:0] exp_col, input bit keyed, input int busy);
        int t0;
        int n;
        wbm_busy_i = (busy > 0);
        start_pixel(1'b1, x, u, v, 32'h0, t0);
        @(posedge clk); #1;
        write_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int b = 0; b < busy; b++) begin
            check32("req_while_busy", {31'b0, texture_request_o}, 32'h0);
            @(posedge clk); #1;
        end
        wbm_busy_i = 1'b0;
        n = 0;
        while (!texture_request_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check32("req_seen", {31'b0, texture_request_o}, 32'h1);
        check32("req_latency", n, (busy > 0) ? 1 : 0);
        if (texture_request_o) begin
            check32("tex_addr", {5'b0, texture_addr_o}, {5'b0, exp_addr});
            @(posedge clk); #1;
            check32("req_held", {31'b0, texture_request_o}, 32'h1);
            texture_data_i = line;
            texture_ack_i  = 1'b1;
            push(!keyed, exp_col, cyc + 1, pixel_x_i, a_i);
            @(posedge clk); #1;
            texture_ack_i  = 1'b0;
            texture_data_i = '0;
            check32("req_dropped", {31'b0, texture_request_o}, 32'h0);
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic set_cfg(input logic [26:0] base, input logic [15:0] sx, input logic [15:0] sy,
                           input logic [1:0] depth, input bit key_en, input logic [31:0] key);
        @(posedge clk); #1;
        tex0_base_i = base; tex0_size_x_i = sx; tex0_size_y_i = sy;
        color_depth_i = depth; colorkey_enable_i = key_en; colorkey_i = key;
    endtask

    initial begin
        int t0;
        int n;
        rst_i = 1'b1;
        texture_enable_i = 0; colorkey_enable_i = 0; colorkey_i = '0; color_depth_i = 2'b10;
        tex0_base_i = '0; tex0_size_x_i = 16'd1; tex0_size_y_i = 16'd1;
        pixel_x_i = '0; pixel_y_i = '0; pixel_z_i = '0; u_i = '0; v_i = '0; a_i = '0;
        color_i = '0; write_i = 0; texture_ack_i = 0; texture_data_i = '0; wbm_busy_i = 0;
        extra_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_write_o", {31'b0, write_o}, 32'h0);
        check32("rst_ack_o", {31'b0, ack_o}, 32'h0);
        check32("rst_request", {31'b0, texture_request_o}, 32'h0);
        check32("rst_addr", {5'b0, texture_addr_o}, 32'h0);
        check32("rst_sel", texture_sel_o, 32'hFFFF_FFFF);
        check32("rst_color", pixel_color_o, 32'h0);
        check32("rst_x", {16'b0, pixel_x_o}, 32'h0);
        rst_i = 1'b0;

        // Flat-color pixels, with and without color-key discard
        flat_pixel(16'd10, 32'h00FF_8040, 1'b0);
        set_cfg(27'h0, 16'd1, 16'd1, 2'b10, 1'b1, 32'h1122_3344);
        flat_pixel(16'd11, 32'h1122_3344, 1'b1);
        set_cfg(27'h0, 16'd1, 16'd1, 2'b01, 1'b1, 32'h0000_5679);
        flat_pixel(16'd12, 32'hABCD_5678, 1'b0);
        set_cfg(27'h0, 16'd1, 16'd1, 2'b01, 1'b1, 32'h9999_5678);
        flat_pixel(16'd13, 32'hABCD_5678, 1'b1);

        // Stray acks while idle must produce nothing
        @(posedge clk); #1;
        extra_ack = 1'b1; texture_ack_i = 1'b1;
        @(posedge clk); #1;
        extra_ack = 1'b0; texture_ack_i = 1'b0;
        repeat (3) @(posedge clk);

        // 16 bpp texel: index 131 -> line 0x108, lane 6
        set_cfg(27'h100, 16'd64, 16'd64, 2'b01, 1'b0, 32'h0);
        ln = {32{8'hEE}}; ln[55:48] = 8'h34; ln[63:56] = 8'h12;
        tex_pixel(16'd20, 16'd3, 16'd2, 27'h108, ln, 32'h0000_1234, 1'b0, 0);

        // Clamp at 32 bpp: u=40 -> 15, index 63 -> line base+7, lane 28
        set_cfg(27'h200, 16'd16, 16'd16, 2'b10, 1'b0, 32'h0);
        ln = {32{8'h11}}; ln[255:224] = 32'hDEAD_BEEF;
        tex_pixel(16'd21, 16'd40, 16'd3, 27'h207, ln, 32'hDEAD_BEEF, 1'b0, 0);

        // 8 bpp color key discard, then an unkeyed 8 bpp texel on another line
        set_cfg(27'h300, 16'd32, 16'd32, 2'b00, 1'b1, 32'h1234_56AA);
        ln = {32{8'h55}}; ln[47:40] = 8'hAA;
        tex_pixel(16'd22, 16'd5, 16'd1, 27'h301, ln, 32'h0, 1'b1, 0);
        ln = {32{8'h55}}; ln[79:72] = 8'hAB;
        tex_pixel(16'd23, 16'd9, 16'd2, 27'h302, ln, 32'h0000_00AB, 1'b0, 0);

        // Reader busy for 5 FETCH cycles
        set_cfg(27'h100, 16'd64, 16'd64, 2'b01, 1'b0, 32'h0);
        ln = {32{8'hCC}}; ln[7:0] = 8'h78; ln[15:8] = 8'h56;
        tex_pixel(16'd24, 16'd0, 16'd0, 27'h100, ln, 32'h0000_5678, 1'b0, 5);

        // Zero-sized texture behaves as 1x1
        set_cfg(27'h040, 16'd0, 16'd0, 2'b10, 1'b0, 32'h0);
        ln = {32{8'h99}}; ln[31:0] = 32'hCAFE_F00D;
        tex_pixel(16'd25, 16'd7, 16'd9, 27'h040, ln, 32'hCAFE_F00D, 1'b0, 0);

        // Reset while a request is outstanding, then a late texture ack
        set_cfg(27'h100, 16'd64, 16'd64, 2'b01, 1'b0, 32'h0);
        start_pixel(1'b1, 16'd26, 16'd3, 16'd2, 32'h0, t0);
        @(posedge clk); #1;
        write_i = 1'b0;
        n = 0;
        while (!texture_request_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check32("rst_fetch_req_seen", {31'b0, texture_request_o}, 32'h1);
        #2 rst_i = 1'b1;
        #1;
        check32("rst_fetch_req_drop", {31'b0, texture_request_o}, 32'h0);
        check32("rst_fetch_write", {31'b0, write_o}, 32'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        texture_data_i = {32{8'h12}}; texture_ack_i = 1'b1;
        @(posedge clk); #1;
        texture_ack_i = 1'b0; texture_data_i = '0;
        repeat (4) @(posedge clk);
        check32("rst_fetch_req_idle", {31'b0, texture_request_o}, 32'h0);

`ifdef GFX256_FRAG_LINE_CACHE_EN
        // Two pixels in one line: second one hits the cache
        set_cfg(27'h180, 16'd64, 16'd64, 2'b01, 1'b0, 32'h0);
        ln = {32{8'h00}}; ln[71:64] = 8'h22; ln[79:72] = 8'h11; ln[87:80] = 8'h44; ln[95:88] = 8'h33;
        tex_pixel(16'd27, 16'd4, 16'd0, 27'h180, ln, 32'h0000_1122, 1'b0, 0);
        start_pixel(1'b1, 16'd28, 16'd5, 16'd0, 32'h0, t0);
        push(1'b1, 32'h0000_3344, t0 + 3, pixel_x_i, a_i);
        @(posedge clk); #1;
        write_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check32("cache_no_request", {31'b0, texture_request_o}, 32'h0);
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
`endif

        // Normal flat operation after the reset
        set_cfg(27'h0, 16'd1, 16'd1, 2'b10, 1'b0, 32'h0);
        flat_pixel(16'd30, 32'h0102_0304, 1'b0);

        check32("scoreboard_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gfx256_fragment.md
# gfx256_fragment

Fragment stage of the gfx256 pipeline, directly downstream of the clip/z-test stage and upstream of the blender. Each accepted pixel is passed through with flat color, or, with texturing enabled, its (u,v) is converted to a 256-bit texture line address, the line is fetched through the wishbone master reader, and the texel is extracted. Pixels whose final color matches the enabled color key are discarded and acknowledged without a write.

## Interface
- point_width, 16, coordinate/depth width
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- texture_enable_i  in  1  1 = color from texture, 0 = flat color_i
- colorkey_enable_i  in  1  enable color-key discard
- colorkey_i  in  32  key compared against final color (depth-masked)
- color_depth_i  in  2  00 = 8 bpp, 01 = 16 bpp, 10/11 = 32 bpp
- tex0_base_i  in  27 [31:5]  texture base, 32-byte line address
- tex0_size_x_i, tex0_size_y_i  in  point_width  texture dimensions
- pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i  in  point_width  from clip
- a_i  in  8  alpha; color_i  in  32  flat color
- write_i  in  1  one-cycle pixel-valid pulse from clip
- ack_o  out  1  one-cycle completion pulse to clip
- texture_addr_o  out  27 [31:5]  line address to reader
- texture_sel_o  out  32  byte select, constant all-ones
- texture_request_o  out  1  read request, held until texture_ack_i
- texture_ack_i  in  1; texture_data_i  in  256  line data, byte 0 at [7:0]
- wbm_busy_i  in  1  reader busy; request not raised while high
- pixel_x_o, pixel_y_o, pixel_z_o  out  point_width  to blender
- pixel_alpha_o  out  8; pixel_color_o  out  32
- write_o  out  1  one-cycle pixel-valid pulse to blender
- ack_i  in  1  blender completion

## Operation
- States: IDLE, ADDR1, ADDR2, FETCH, WRITE.
- IDLE: on write_i capture x,y,z,u,v,a,color_i. texture_enable_i=0 -> WRITE path (key check on color_i); =1 -> ADDR1. write_i outside IDLE is a protocol error; ignored.
- Clamp: u' = min(u, size_x-1), v' = min(v, size_y-1); size 0 treated as 1.
- ADDR1: register index = v'*size_x + u' (32-bit unsigned product).
- ADDR2: byte offset = index << {0,1,2} per depth; texture_addr_o = tex0_base_i + offset[31:5]; lane = offset[4:0]; -> FETCH.
- FETCH: raise texture_request_o when wbm_busy_i=0; hold until texture_ack_i; on ack, drop request, extract texel at byte lane (8 bpp zero-extended to 32, 16 bpp zero-extended, 32 bpp full), run key check.
- Key check: colorkey_enable_i and color[depth bits] == colorkey_i[depth bits] -> pulse ack_o, -> IDLE, no write_o. Else pulse write_o, -> WRITE.
- WRITE: wait ack_i; on ack_i pulse ack_o next cycle, -> IDLE.
- Outputs pixel_*_o stable from write_o until ack_i; alpha = captured a_i.

## Timing
- Reset: state IDLE; ack_o, write_o, texture_request_o 0; texture_addr_o, pixel_*_o, pixel_alpha_o, pixel_color_o 0; texture_sel_o 32'hFFFFFFFF.
- Flat path: write_i at cycle 0 -> write_o at cycle 1; ack_i at cycle n -> ack_o at n+1.
- Texture path: write_i at 0 -> request earliest cycle 3 -> texture_ack_i at k -> write_o (or discard ack_o) at k+1.
- ack_i and texture_ack_i outside the expecting state are ignored.
- Reset mid-fetch: request drops immediately; a late texture_ack_i after reset is ignored.
- ack_i coincident with write_o is illegal; blender acks no earlier than cycle after write_o.

## Configuration
- GFX256_FRAG_LINE_CACHE_EN defined: one-line cache (valid bit, tag [31:5], 256-bit data). ADDR2 tag hit -> texel from cache, no request, write_o at cycle 3 after write_i. Miss fills on texture_ack_i. Valid cleared on reset and on any change of tex0_base_i or color_depth_i.
- Undefined: every textured pixel issues a fetch; no cache storage.

## Test plan
- Flat: texture_enable_i=0, color_i=32'h00FF8040, write_i -> write_o cycle 1 with same color; ack_i -> ack_o next cycle.
- 16 bpp texel: base 27'h100, size_x=64, u=3, v=2 -> texture_addr_o=27'h108, lane 6; data bytes 6..7 = 34 12 -> pixel_color_o=32'h00001234.
- Clamp: size 16x16, u=40, v=3 at 32 bpp -> index 63, texture_addr_o=base+7, lane 28.
- Color key: 8 bpp, key 8'hAA enabled, texel AA -> ack_o pulse, write_o never asserted, back to IDLE.
- wbm_busy_i high 5 cycles in FETCH -> no request until busy drops; then request held until texture_ack_i.
- With GFX256_FRAG_LINE_CACHE_EN: two pixels in same line -> one request only; second write_o 3 cycles after its write_i.
